// File: rtl/fifo_chk_pkg.sv
// Shared types, default widths and helpers for the FIFO read checker.
package fifo_chk_pkg;

    // Checker FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_CHECK = 2'd3
    } chk_state_e;

    localparam int DEF_DATA_WIDTH   = 8;
    localparam int DEF_CNT_WIDTH    = 16;
    localparam int DEF_READ_LATENCY = 1;

    // Increment that sticks at the all-ones value of a width-bit counter (width <= 31).
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [32:0] max_val;
        max_val = (33'd1 << width) - 33'd1;
        sat_inc = (33'(val) >= max_val) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter
    import fifo_chk_pkg::*;
#(
    parameter int WIDTH = DEF_CNT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: clear, saturating increment, or hold.
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc) begin
            count_d = WIDTH'(sat_inc(32'(count_q), WIDTH));
        end
    end

    // Count register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/fifo_read_checker.sv
// Read-side consumer for the async-FIFO test path: pulls one word at a time
// and checks it against an incrementing expected sequence.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | no read outstanding; start one when enabled and non-empty
//   ST_ISSUE | rd_en high for this single cycle
//   ST_WAIT  | lat_cnt counting down the remaining read latency
//   ST_CHECK | rd_data valid; compare and update at the end of the cycle
module fifo_read_checker
    import fifo_chk_pkg::*;
#(
    parameter int                    DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int                    CNT_WIDTH    = DEF_CNT_WIDTH,
    parameter int                    READ_LATENCY = DEF_READ_LATENCY,
    parameter logic [DATA_WIDTH-1:0] SEED         = '0,
    parameter bit                    RESYNC       = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear,
    input  logic                  empty,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_en,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  match_cnt,
    output logic [CNT_WIDTH-1:0]  err_cnt,
    output logic                  error,
    output logic [DATA_WIDTH-1:0] first_err_data,
    output logic [DATA_WIDTH-1:0] first_err_exp
);

    // ISSUE accounts for one latency cycle and CHECK for the last one.
    localparam logic [1:0] LAT_LOAD = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

    chk_state_e            state_q, state_d;
    logic                  rd_en_q, rd_en_d;
    logic                  busy_q, busy_d;
    logic [1:0]            lat_cnt_q, lat_cnt_d;
    logic [DATA_WIDTH-1:0] exp_q, exp_d;
    logic                  error_q, error_d;
    logic [DATA_WIDTH-1:0] fed_q, fed_d;
    logic [DATA_WIDTH-1:0] fee_q, fee_d;
    logic                  match_inc;
    logic                  err_inc;

    // Next-state, read strobe and check results; clear overrides everything.
    always_comb begin
        state_d   = state_q;
        rd_en_d   = 1'b0;
        lat_cnt_d = lat_cnt_q;
        exp_d     = exp_q;
        error_d   = error_q;
        fed_d     = fed_q;
        fee_d     = fee_q;
        match_inc = 1'b0;
        err_inc   = 1'b0;
        if (clear) begin
            state_d = ST_IDLE;
            exp_d   = SEED;
            error_d = 1'b0;
            fed_d   = '0;
            fee_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable && !empty) begin
                        state_d = ST_ISSUE;
                        rd_en_d = 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (READ_LATENCY == 1) begin
                        state_d = ST_CHECK;
                    end else begin
                        lat_cnt_d = LAT_LOAD;
                        state_d   = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (lat_cnt_q == 2'd0) begin
                        state_d = ST_CHECK;
                    end else begin
                        lat_cnt_d = lat_cnt_q - 2'd1;
                    end
                end
                ST_CHECK: begin
                    state_d = ST_IDLE;
                    if (rd_data == exp_q) begin
                        match_inc = 1'b1;
                        exp_d     = exp_q + 1'b1;
                    end else begin
                        err_inc = 1'b1;
                        if (!error_q) begin
                            error_d = 1'b1;
                            fed_d   = rd_data;
                            fee_d   = exp_q;
                        end
                        exp_d = RESYNC ? rd_data + 1'b1 : exp_q + 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and registered outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            lat_cnt_q <= 2'd0;
            exp_q     <= SEED;
            error_q   <= 1'b0;
            fed_q     <= '0;
            fee_q     <= '0;
        end else begin
            state_q   <= state_d;
            rd_en_q   <= rd_en_d;
            busy_q    <= busy_d;
            lat_cnt_q <= lat_cnt_d;
            exp_q     <= exp_d;
            error_q   <= error_d;
            fed_q     <= fed_d;
            fee_q     <= fee_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_match_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (match_inc),
        .clr   (clear),
        .count (match_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (err_inc),
        .clr   (clear),
        .count (err_cnt)
    );

    assign rd_en          = rd_en_q;
    assign busy           = busy_q;
    assign error          = error_q;
    assign first_err_data = fed_q;
    assign first_err_exp  = fee_q;

endmodule
